// File: rtl/hsv_to_rgb.sv
// HSV (degrees / percent) to 8-bit RGB converter built around one shared restoring divider.
// Optional: define HSV_TO_RGB_GRAY_BYPASS_EN to skip the p/q/t divisions when saturation is 0.
module hsv_to_rgb (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] h,
  input  logic [6:0] s,
  input  logic [6:0] v,
  input  logic       valid_in,
  output logic       ready_in,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       err,
  output logic       valid_out,
  input  logic       ready_out
);

  typedef enum logic [2:0] {IDLE, PREP, DIV_V, DIV_P, DIV_Q, DIV_T, OUT} state_t;

  localparam logic [13:0] DIVISOR  = 14'd6000;
  localparam logic [4:0]  LAST_CNT = 5'd20;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [8:0]  h_q;
  logic [6:0]  s_q, v_q;
  logic [2:0]  sec, sec_c;
  logic [5:0]  frac, frac_c;
  logic [20:0] dvd, quo, quo_step;
  logic [12:0] rem, rem_step;
  logic [13:0] trial, diff;
  logic        fits, last, gray;
  logic [7:0]  v8, p_val, q_val, res;

  function automatic logic [20:0] dvd_v(input logic [6:0] vv);
    logic [20:0] x;
    x = 21'(vv) * 21'd15300 + 21'd3000;
    return x;
  endfunction

  function automatic logic [20:0] dvd_p(input logic [7:0] vx, input logic [6:0] ss);
    logic [20:0] x;
    x = 21'(vx) * 21'(7'd100 - ss) * 21'd60 + 21'd3000;
    return x;
  endfunction

  // q and t share one form; ff is f for q and (60 - f) for t
  function automatic logic [20:0] dvd_qt(input logic [7:0] vx, input logic [6:0] ss,
                                         input logic [6:0] ff);
    logic [20:0] x;
    x = 21'(vx) * (21'd6000 - 21'(ss) * 21'(ff)) + 21'd3000;
    return x;
  endfunction

  function automatic logic [23:0] sector_map(input logic [2:0] i, input logic [7:0] vx,
                                             input logic [7:0] px, input logic [7:0] qx,
                                             input logic [7:0] tx);
    logic [23:0] rgb;
    case (i)
      3'd0:    rgb = {vx, tx, px};
      3'd1:    rgb = {qx, vx, px};
      3'd2:    rgb = {px, vx, tx};
      3'd3:    rgb = {px, qx, vx};
      3'd4:    rgb = {tx, px, vx};
      default: rgb = {vx, px, qx};
    endcase
    return rgb;
  endfunction

`ifdef HSV_TO_RGB_GRAY_BYPASS_EN
  assign gray = (s_q == 7'd0);
`else
  assign gray = 1'b0;
`endif

  assign ready_in  = (state == IDLE) && rst;
  assign valid_out = (state == OUT);
  assign last      = (cnt == LAST_CNT);

  // one restoring step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    trial    = {rem, dvd[20]};
    diff     = trial - DIVISOR;
    fits     = (trial >= DIVISOR);
    rem_step = fits ? diff[12:0] : trial[12:0];
    quo_step = {quo[19:0], fits};
    res      = quo_step[7:0];
  end

  always_comb begin
    sec_c  = 3'd5;
    frac_c = 6'(h_q - 9'd300);
    if (h_q < 9'd60) begin
      sec_c  = 3'd0;
      frac_c = h_q[5:0];
    end else if (h_q < 9'd120) begin
      sec_c  = 3'd1;
      frac_c = 6'(h_q - 9'd60);
    end else if (h_q < 9'd180) begin
      sec_c  = 3'd2;
      frac_c = 6'(h_q - 9'd120);
    end else if (h_q < 9'd240) begin
      sec_c  = 3'd3;
      frac_c = 6'(h_q - 9'd180);
    end else if (h_q < 9'd300) begin
      sec_c  = 3'd4;
      frac_c = 6'(h_q - 9'd240);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in) state_nxt = PREP;
      PREP:    state_nxt = DIV_V;
      DIV_V:   if (last) state_nxt = gray ? OUT : DIV_P;
      DIV_P:   if (last) state_nxt = DIV_Q;
      DIV_Q:   if (last) state_nxt = DIV_T;
      DIV_T:   if (last) state_nxt = OUT;
      OUT:     if (ready_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      h_q   <= '0;
      s_q   <= '0;
      v_q   <= '0;
      sec   <= '0;
      frac  <= '0;
      dvd   <= '0;
      rem   <= '0;
      quo   <= '0;
      v8    <= '0;
      p_val <= '0;
      q_val <= '0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          h_q <= (h >= 9'd360) ? h - 9'd360 : h;
          s_q <= (s > 7'd100) ? 7'd100 : s;
          v_q <= (v > 7'd100) ? 7'd100 : v;
          err <= (h >= 9'd360) || (s > 7'd100) || (v > 7'd100);
        end
        PREP: begin
          sec  <= sec_c;
          frac <= frac_c;
          dvd  <= dvd_v(v_q);
          rem  <= '0;
          quo  <= '0;
          cnt  <= '0;
        end
        DIV_V, DIV_P, DIV_Q, DIV_T: begin
          if (last) begin
            // final step result is consumed directly and the next dividend loaded
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            case (state)
              DIV_V: begin
                v8  <= res;
                dvd <= dvd_p(res, s_q);
                if (gray) begin
                  r <= res;
                  g <= res;
                  b <= res;
                end
              end
              DIV_P: begin
                p_val <= res;
                dvd   <= dvd_qt(v8, s_q, {1'b0, frac});
              end
              DIV_Q: begin
                q_val <= res;
                dvd   <= dvd_qt(v8, s_q, 7'd60 - {1'b0, frac});
              end
              DIV_T:   {r, g, b} <= sector_map(sec, v8, p_val, q_val, res);
              default: ;
            endcase
          end else begin
            cnt <= cnt + 5'd1;
            dvd <= {dvd[19:0], 1'b0};
            rem <= rem_step;
            quo <= quo_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hsv_to_rgb.md
HSV_TO_RGB -- requirements
Module: hsv_to_rgb

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-003 h  input  9  hue, integer degrees, legal 0..359.
REQ-004 s  input  7  saturation, integer percent, legal 0..100.
REQ-005 v  input  7  value, integer percent, legal 0..100.
REQ-006 valid_in  input  1  h/s/v valid this cycle.
REQ-007 ready_in  output  1  block can accept; high only in IDLE.
REQ-008 r, g, b  output  8 each  result channels 0..255, stable while valid_out=1.
REQ-009 err  output  1  at least one input was out of range and was corrected; qualified by valid_out.
REQ-010 valid_out  output  1  result valid.
REQ-011 ready_out  input  1  downstream accepts result.

Function
REQ-012 Acceptance SHALL occur on a rising edge with valid_in=1 and ready_in=1; h, s and v are registered at that edge; input changes afterwards SHALL NOT affect the result.
REQ-013 Input correction SHALL be: h>=360 -> h-360; s>100 -> 100; v>100 -> 100; err=1 if any correction was applied.
REQ-014 FSM states SHALL be IDLE, PREP, DIV_V, DIV_P, DIV_Q, DIV_T, OUT; acceptance moves IDLE->PREP; PREP lasts 1 cycle; each DIV_x state lasts 21 cycles, then moves to the next state in the listed order; DIV_T moves to OUT.
REQ-015 PREP SHALL compute sector i=floor(h/60) (0..5) and f=h-60*i (0..59) using comparisons, without a divider.
REQ-016 Division SHALL use one shared 21-bit restoring divider: 1 quotient bit per cycle, divisor constant 6000, truncating quotient.
REQ-017 Dividends SHALL be: V8 from v*15300+3000; p from V8*(100-s)*60+3000; q from V8*(6000-s*f)+3000; t from V8*(6000-s*(60-f))+3000; maximum dividend 1,533,000 (<2^21).
REQ-018 Output mapping (r,g,b) by sector SHALL be: 0:(V8,t,p) 1:(q,V8,p) 2:(p,V8,t) 3:(p,q,V8) 4:(t,p,V8) 5:(V8,p,q).
REQ-019 Full-path latency SHALL be fixed: valid_out first high 85 rising edges after the acceptance edge.
REQ-020 In OUT, valid_out=1 and r/g/b/err SHALL be held until an edge with ready_out=1; that edge returns the FSM to IDLE, and ready_in=1 on the following cycle.
REQ-021 No new acceptance SHALL occur in the cycle where OUT completes; valid_in during a busy state SHALL be ignored and SHALL NOT be queued.

Reset
REQ-022 rst=0 at a rising edge SHALL force IDLE, r=g=b=0, err=0, valid_out=0, clear the divider state and discard any in-flight operation, including one in OUT.
REQ-023 ready_in SHALL be 0 while rst=0 and 1 in the first cycle after reset is released.

Configuration
REQ-024 With macro HSV_TO_RGB_GRAY_BYPASS_EN defined and corrected s=0, the FSM SHALL go DIV_V->OUT with r=g=b=V8, so valid_out first rises 22 edges after acceptance.
REQ-025 Without HSV_TO_RGB_GRAY_BYPASS_EN, every transaction SHALL take the full path; result values SHALL be identical in both builds, and only latency differs.

Verification
REQ-026 h=0,s=100,v=100 -> (255,0,0), err=0, valid_out at edge 85.
REQ-027 h=30,s=50,v=100 -> (255,191,128); h=60,s=100,v=50 -> (128,128,0); h=240,s=100,v=100 -> (0,0,255).
REQ-028 h=400,s=120,v=100 -> treated as h=40,s=100 -> (255,170,0), err=1.
REQ-029 s=0,v=100 -> (255,255,255); valid_out at edge 22 with HSV_TO_RGB_GRAY_BYPASS_EN defined, edge 85 without it.
REQ-030 ready_out held 0 for 10 cycles in OUT -> r/g/b stable and ready_in=0 throughout; valid_in pulses during busy states produce no extra result.
REQ-031 rst=0 asserted for 1 cycle during DIV_Q -> next cycle all outputs 0, then ready_in=1; a new transaction afterwards completes with correct values.
